// File: rtl/gpio_in_cond.sv
// Per-pin pad input conditioner: 2-flop synchronizer, optional debounce filter,
// registered level plus one-cycle rise/fall pulses and an aggregate edge flag.
module gpio_in_cond #(
  parameter int NO_OF_GPIO_PINS = 24,
  parameter int DEBOUNCE_W      = 8
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [NO_OF_GPIO_PINS-1:0] pad_i,
  input  logic [NO_OF_GPIO_PINS-1:0] db_en_i,
  input  logic [DEBOUNCE_W-1:0]      db_limit_i,
  output logic [NO_OF_GPIO_PINS-1:0] gpio_o,
  output logic [NO_OF_GPIO_PINS-1:0] rise_o,
  output logic [NO_OF_GPIO_PINS-1:0] fall_o,
  output logic                       edge_o
);

  logic [NO_OF_GPIO_PINS-1:0] s1;
  logic [NO_OF_GPIO_PINS-1:0] s;
  logic [NO_OF_GPIO_PINS-1:0] q;
  logic [NO_OF_GPIO_PINS-1:0] q_next;
  logic [NO_OF_GPIO_PINS-1:0] rise_next;
  logic [NO_OF_GPIO_PINS-1:0] fall_next;
  logic [DEBOUNCE_W-1:0]      cnt      [NO_OF_GPIO_PINS];
  logic [DEBOUNCE_W-1:0]      cnt_next [NO_OF_GPIO_PINS];

  // A pin only commits a new level after s has disagreed with q for L+1
  // consecutive cycles; the >= compare keeps the counter from ever exceeding L,
  // so a limit lowered mid-count commits on the very next cycle.
  always_comb begin
    for (int i = 0; i < NO_OF_GPIO_PINS; i++) begin
      q_next[i]   = q[i];
      cnt_next[i] = '0;
      if (!db_en_i[i]) begin
        q_next[i] = s[i];
      end else if (s[i] != q[i]) begin
        if (cnt[i] >= db_limit_i) begin
          q_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
    rise_next = q_next & ~q;
    fall_next = ~q_next & q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1     <= '0;
      s      <= '0;
      q      <= '0;
      rise_o <= '0;
      fall_o <= '0;
      edge_o <= 1'b0;
      for (int i = 0; i < NO_OF_GPIO_PINS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1     <= pad_i;
      s      <= s1;
      q      <= q_next;
      rise_o <= rise_next;
      fall_o <= fall_next;
      edge_o <= |(rise_next | fall_next);
      for (int i = 0; i < NO_OF_GPIO_PINS; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign gpio_o = q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond: reset, bypass latency, debounce, glitch
// rejection, limit change, simultaneous edges and reset mid-debounce.
module tb_gpio_in_cond;

  localparam int N = 24;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pad = '0;
  logic [N-1:0] db_en = '0;
  logic [W-1:0] lim = '0;
  logic [N-1:0] gpio, rise, fall;
  logic         edg;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  gpio_in_cond #(.NO_OF_GPIO_PINS(N), .DEBOUNCE_W(W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .pad_i     (pad),
    .db_en_i   (db_en),
    .db_limit_i(lim),
    .gpio_o    (gpio),
    .rise_o    (rise),
    .fall_o    (fall),
    .edge_o    (edg)
  );

  // advance one rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    pad   = '0;
    db_en = '0;
    lim   = '0;
    repeat (5) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pad = 24'h000001;
    repeat (3) step();
    total_cnt++;
    if (gpio !== 24'h0) $display("FAIL reset_gpio: got %h want %h", gpio, 24'h0);
    else pass_cnt++;
    total_cnt++;
    if ({rise, fall, edg} !== '0) $display("FAIL reset_pulses: got %h/%h/%b want 0", rise, fall, edg);
    else pass_cnt++;
    rst = 1'b0;
    repeat (2) step();
    total_cnt++;
    if (gpio !== 24'h0) $display("FAIL reset_early: got %h want %h at edge 2", gpio, 24'h0);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({gpio, rise, edg} !== {24'h000001, 24'h000001, 1'b1})
      $display("FAIL reset_rise: got gpio=%h rise=%h edge=%b want 000001/000001/1", gpio, rise, edg);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({gpio, rise, edg} !== {24'h000001, 24'h000000, 1'b0})
      $display("FAIL reset_rise_once: got gpio=%h rise=%h edge=%b want 000001/000000/0", gpio, rise, edg);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    pad = 24'h000021;
    repeat (2) step();
    total_cnt++;
    if (gpio[5] !== 1'b0) $display("FAIL bypass_early: got %b want 0", gpio[5]);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({gpio, rise, fall} !== {24'h000021, 24'h000020, 24'h0})
      $display("FAIL bypass_rise: got gpio=%h rise=%h fall=%h want 000021/000020/000000", gpio, rise, fall);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({rise, edg} !== {24'h0, 1'b0}) $display("FAIL bypass_rise_len: got rise=%h edge=%b want 0/0", rise, edg);
    else pass_cnt++;
    pad = 24'h000001;
    repeat (3) step();
    total_cnt++;
    if ({gpio, rise, fall, edg} !== {24'h000001, 24'h0, 24'h000020, 1'b1})
      $display("FAIL bypass_fall: got gpio=%h rise=%h fall=%h edge=%b want 000001/000000/000020/1", gpio, rise, fall, edg);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({fall, edg} !== {24'h0, 1'b0}) $display("FAIL bypass_fall_len: got fall=%h edge=%b want 0/0", fall, edg);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    settle();
    pad = 24'h800001;
    repeat (2) step();
    total_cnt++;
    if ({rise, edg} !== {24'h0, 1'b0}) $display("FAIL simul_early: got rise=%h edge=%b want 0/0", rise, edg);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({gpio, rise, edg} !== {24'h800001, 24'h800001, 1'b1})
      $display("FAIL simul_rise: got gpio=%h rise=%h edge=%b want 800001/800001/1", gpio, rise, edg);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({rise, edg} !== {24'h0, 1'b0}) $display("FAIL simul_once: got rise=%h edge=%b want 0/0", rise, edg);
    else pass_cnt++;
  endtask

  task automatic test_debounce();
    logic bad;
    settle();
    db_en = 24'h000004;
    lim   = 8'd4;
    pad   = 24'h000004;
    repeat (6) step();
    total_cnt++;
    if ({gpio[2], rise[2]} !== 2'b00) $display("FAIL db_early: got gpio=%b rise=%b at edge 6 want 0/0", gpio[2], rise[2]);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({gpio, rise, edg} !== {24'h000004, 24'h000004, 1'b1})
      $display("FAIL db_rise: got gpio=%h rise=%h edge=%b want 000004/000004/1", gpio, rise, edg);
    else pass_cnt++;
    repeat (3) step();
    total_cnt++;
    if ({gpio[2], rise[2]} !== 2'b10) $display("FAIL db_rise_once: got gpio=%b rise=%b want 1/0", gpio[2], rise[2]);
    else pass_cnt++;
    pad = '0;
    repeat (7) step();
    total_cnt++;
    if ({gpio[2], fall[2]} !== 2'b01) $display("FAIL db_fall: got gpio=%b fall=%b at edge 7 want 0/1", gpio[2], fall[2]);
    else pass_cnt++;
    repeat (3) step();
    // four cycles of mismatch at s must be rejected
    pad = 24'h000004;
    repeat (4) step();
    pad = '0;
    bad = 1'b0;
    repeat (10) begin
      step();
      if (gpio[2] !== 1'b0 || rise[2] !== 1'b0 || edg !== 1'b0) bad = 1'b1;
    end
    total_cnt++;
    if (bad !== 1'b0) $display("FAIL db_glitch: got disturbance=%b want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (dut.cnt[2] !== 8'd0) $display("FAIL db_glitch_cnt: got %0d want 0", dut.cnt[2]);
    else pass_cnt++;
  endtask

  task automatic test_limit_change();
    settle();
    db_en = 24'h000008;
    lim   = 8'd200;
    pad   = 24'h000008;
    repeat (52) step();
    total_cnt++;
    if ({gpio[3], dut.cnt[3]} !== {1'b0, 8'd50})
      $display("FAIL lim_count: got gpio=%b cnt=%0d want 0/50", gpio[3], dut.cnt[3]);
    else pass_cnt++;
    lim = 8'd10;
    step();
    total_cnt++;
    if ({gpio[3], rise[3], edg} !== 3'b111)
      $display("FAIL lim_update: got gpio=%b rise=%b edge=%b want 1/1/1", gpio[3], rise[3], edg);
    else pass_cnt++;
    total_cnt++;
    if (dut.cnt[3] !== 8'd0) $display("FAIL lim_cnt_clear: got %0d want 0", dut.cnt[3]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    settle();
    pad = 24'h000020;
    repeat (4) step();
    db_en = 24'h000010;
    lim   = 8'd8;
    pad   = 24'h000030;
    repeat (5) step();
    total_cnt++;
    if ({gpio, dut.cnt[4]} !== {24'h000020, 8'd3})
      $display("FAIL mid_pre: got gpio=%h cnt=%0d want 000020/3", gpio, dut.cnt[4]);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({gpio, rise, fall, edg} !== '0)
      $display("FAIL mid_async: got gpio=%h rise=%h fall=%h edge=%b want all 0", gpio, rise, fall, edg);
    else pass_cnt++;
    total_cnt++;
    if (dut.cnt[4] !== 8'd0) $display("FAIL mid_cnt: got %0d want 0", dut.cnt[4]);
    else pass_cnt++;
    step();
    rst = 1'b0;
    repeat (10) step();
    total_cnt++;
    if (gpio[4] !== 1'b0) $display("FAIL mid_early: got %b at edge 10 want 0", gpio[4]);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({gpio[4], rise[4]} !== 2'b11) $display("FAIL mid_rise: got gpio=%b rise=%b at edge 11 want 1/1", gpio[4], rise[4]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_simultaneous();
    test_debounce();
    test_limit_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
- Per-pin input conditioner that sits directly upstream of the Wishbone GPIO register block and drives its `i_gpio` bus.
- Each pad input passes through a 2-flop synchronizer and an optional per-pin debounce filter.
- It produces a clean level plus one-cycle rise and fall pulses per pin, and an aggregate edge flag for the future interrupt logic.
- Runs entirely in the Wishbone clock domain.

Parameters:
- NO_OF_GPIO_PINS, 24, number of conditioned pins; must match the GPIO register block.
- DEBOUNCE_W, 8, width of the per-pin debounce counter and of the limit input.

Ports:
- wb_clk_i  input  1  system/Wishbone clock; all flops rising-edge.
- wb_rst_i  input  1  asynchronous, active-high reset.
- pad_i  input  NO_OF_GPIO_PINS  raw asynchronous pad inputs.
- db_en_i  input  NO_OF_GPIO_PINS  per-pin debounce enable (1 = filter, 0 = bypass); quasi-static.
- db_limit_i  input  DEBOUNCE_W  shared debounce threshold L; quasi-static.
- gpio_o  output  NO_OF_GPIO_PINS  conditioned level; connects to GPIO block `i_gpio`.
- rise_o  output  NO_OF_GPIO_PINS  one-cycle pulse when gpio_o[i] goes 0->1.
- fall_o  output  NO_OF_GPIO_PINS  one-cycle pulse when gpio_o[i] goes 1->0.
- edge_o  output  1  one-cycle pulse = OR of all rise_o/fall_o bits in the same cycle.

Behaviour:
- Reset (async assert, sync release):
  - Sync flops, counters, gpio_o, rise_o, fall_o and edge_o are all 0.
  - A pad held high through reset produces one rise_o pulse after release, with normal latency. This is intended.
- Synchronizer:
  - s1[i] <= pad_i[i], then s[i] <= s1[i].
  - No logic between the two stages.
- Bypass (db_en_i[i]=0):
  - Next q[i] = s[i] every cycle; cnt[i] <= 0.
  - A pad change held stable is visible on gpio_o at the 3rd rising edge after it.
- Debounce (db_en_i[i]=1), per pin, per cycle:
  - If s[i]==q[i]: cnt[i] <= 0.
  - Else if cnt[i] >= L: q[i] <= s[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Result: gpio_o changes only after s differs from q for L+1 consecutive cycles. Latency from pad edge is 3+L edges.
  - L=0 behaves identically to bypass.
  - The counter never exceeds L. It never wraps because the compare is >=.
- Glitches:
  - Any return of s to q before expiry clears cnt; no output change, no pulse.
  - Alternating input restarts the count on every mismatch run.
- Limit changed mid-count:
  - Takes effect the next cycle.
  - If the new L <= the current cnt, q updates on that cycle.
- db_en_i[i] 1->0 mid-count: cnt cleared; q follows s on the next edge.
- Edge pulses:
  - rise_o[i] <= q_next[i] & ~q[i]; fall_o[i] <= ~q_next[i] & q[i]; edge_o <= |(rise_next|fall_next).
  - All outputs are registered and asserted in the same cycle that gpio_o first shows the new value.
  - Duration is exactly one cycle.
  - rise and fall on one pin are mutually exclusive.
  - Simultaneous edges on several pins give one edge_o pulse.
- Pins are fully independent; no cross-pin state.
- All outputs are driven directly from flops; no combinational path from any input to any output.

Test Plan:
- Reset with pad_i=24'h000001 held; release:
  - gpio_o=0 during reset.
  - gpio_o[0]=1 with rise_o[0]=1 and edge_o=1 for one cycle at the 3rd edge after release.
- Bypass, pad_i[5] 0->1:
  - gpio_o[5]=1 at edge 3; rise_o[5] high exactly that cycle.
  - Then pad 1->0 gives fall_o[5] pulse 3 edges later.
- db_en_i[2]=1, L=4, pad_i[2] high for 10 cycles:
  - gpio_o[2] rises at edge 7 (3+4); single rise pulse.
  - A 4-cycle high glitch (4 cycles of mismatch at s) produces no change and no pulse.
- db_en_i[3]=1, L=200, pad high:
  - Set L=10 after 50 mismatch cycles; gpio_o[3] updates on the next edge.
  - cnt reads 0 afterward.
- Simultaneous rise on pins 0 and 23 (bypass):
  - rise_o=24'h800001 and edge_o=1 for one cycle.
- Assert wb_rst_i mid-debounce (cnt=3, L=8):
  - All outputs 0 immediately (async).
  - After release, a held pad requires the full 3+8 edges to propagate.
